// File: rtl/product_accumulator.sv
// Frame accumulator for the 4x4 multiplier product: sums N_TERMS products with
// saturation and offers the frame sum on a valid/ready output port.
module product_accumulator #(
  parameter int PROD_W  = 8,
  parameter int ACC_W   = 12,
  parameter int N_TERMS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Returns {saturated, clamped_sum}; the add is done one bit wider than the accumulator.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
    if (sum[ACC_W]) begin
      sat_add = {1'b1, ACC_MAX};
    end else begin
      sat_add = sum;
    end
  endfunction

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sat_s;

  assign sat_s     = sat_add(acc_q, prod);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = (state_q == ST_ACCUM);

  // Next-state logic: clr overrides input accept and output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = ST_ACCUM;
      acc_d   = ACC_ZERO;
      cnt_d   = CNT_ZERO;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid) begin
            acc_d = sat_s[ACC_W-1:0];
            ovf_d = ovf_q | sat_s[ACC_W];
            if (cnt_q == CNT_LAST) begin
              cnt_d   = CNT_ZERO;
              state_d = ST_HOLD;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          // Result stays frozen until downstream takes it; inputs are not consumed here.
          if (out_ready) begin
            state_d = ST_ACCUM;
            acc_d   = ACC_ZERO;
            cnt_d   = CNT_ZERO;
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_ACCUM;
          acc_d   = ACC_ZERO;
          cnt_d   = CNT_ZERO;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= ACC_ZERO;
      cnt_q   <= CNT_ZERO;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: default-sized accumulator plus a 10-bit / 8-term instance
// for saturation; expected values are hand-computed constants.
module tb_product_accumulator;

  logic        clk;
  logic        rst;

  logic        a_clr, a_in_valid, a_in_ready, a_ovf, a_out_valid, a_out_ready;
  logic [7:0]  a_prod;
  logic [11:0] a_acc_out;

  logic        b_clr, b_in_valid, b_in_ready, b_ovf, b_out_valid, b_out_ready;
  logic [7:0]  b_prod;
  logic [9:0]  b_acc_out;

  int n_checks;
  int n_pass;

  product_accumulator u_def (
    .clk       (clk),
    .rst       (rst),
    .clr       (a_clr),
    .prod      (a_prod),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .acc_out   (a_acc_out),
    .ovf       (a_ovf),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(10), .N_TERMS(8)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .clr       (b_clr),
    .prod      (b_prod),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .acc_out   (b_acc_out),
    .ovf       (b_ovf),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    if (obs === exp_v) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] p);
    a_prod     = p;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p);
    b_prod     = p;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    a_clr       = 1'b0; a_in_valid = 1'b0; a_prod = 8'd0; a_out_ready = 1'b0;
    b_clr       = 1'b0; b_in_valid = 1'b0; b_prod = 8'd0; b_out_ready = 1'b0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_acc_out",   32'(a_acc_out),   32'd0);
    chk("rst_ovf",       32'(a_ovf),       32'd0);
    tick();
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("post_rst_b_ready",  32'(b_in_ready), 32'd1);

    // Basic frame
    send_a(8'd15);
    send_a(8'd30);
    send_a(8'd45);
    chk("basic_acc3",      32'(a_acc_out),   32'd90);
    chk("basic_not_valid", 32'(a_out_valid), 32'd0);
    send_a(8'd225);
    chk("basic_out_valid", 32'(a_out_valid), 32'd1);
    chk("basic_acc_out",   32'(a_acc_out),   32'd315);
    chk("basic_ovf",       32'(a_ovf),       32'd0);
    chk("basic_in_ready",  32'(a_in_ready),  32'd0);
    release_a();
    chk("release_valid", 32'(a_out_valid), 32'd0);
    chk("release_ready", 32'(a_in_ready),  32'd1);
    chk("release_acc",   32'(a_acc_out),   32'd0);

    // Gaps between terms and backpressure in HOLD
    send_a(8'd15);
    tick();
    chk("gap_acc1", 32'(a_acc_out), 32'd15);
    send_a(8'd30);
    tick();
    tick();
    chk("gap_acc2", 32'(a_acc_out), 32'd45);
    send_a(8'd45);
    tick();
    send_a(8'd225);
    chk("gap_valid", 32'(a_out_valid), 32'd1);
    a_prod     = 8'd99;
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_acc",   32'(a_acc_out),   32'd315);
      chk("bp_valid", 32'(a_out_valid), 32'd1);
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    chk("bp_done_acc",   32'(a_acc_out),  32'd0);
    chk("bp_done_ready", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 4; i++) send_a(8'd1);
    chk("ones_valid", 32'(a_out_valid), 32'd1);
    chk("ones_acc",   32'(a_acc_out),   32'd4);
    release_a();

    // Saturation on the 10-bit, 8-term instance
    for (int i = 0; i < 4; i++) send_b(8'd225);
    chk("sat_acc4", 32'(b_acc_out), 32'd900);
    chk("sat_ovf4", 32'(b_ovf),     32'd0);
    send_b(8'd225);
    chk("sat_acc5", 32'(b_acc_out), 32'd1023);
    chk("sat_ovf5", 32'(b_ovf),     32'd1);
    chk("sat_nv5",  32'(b_out_valid), 32'd0);
    for (int i = 0; i < 3; i++) send_b(8'd225);
    chk("sat_valid", 32'(b_out_valid), 32'd1);
    chk("sat_acc",   32'(b_acc_out),   32'd1023);
    chk("sat_ovf",   32'(b_ovf),       32'd1);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    send_b(8'd1);
    chk("sat_next_ovf", 32'(b_ovf),     32'd0);
    chk("sat_next_acc", 32'(b_acc_out), 32'd1);

    // clr mid-frame drops the coincident input
    send_a(8'd10);
    send_a(8'd20);
    chk("clr_pre_acc", 32'(a_acc_out), 32'd30);
    a_clr      = 1'b1;
    a_prod     = 8'd50;
    a_in_valid = 1'b1;
    tick();
    a_clr      = 1'b0;
    a_in_valid = 1'b0;
    chk("clr_acc",   32'(a_acc_out),  32'd0);
    chk("clr_ready", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 4; i++) send_a(8'd1);
    chk("clr_frame_valid", 32'(a_out_valid), 32'd1);
    chk("clr_frame_acc",   32'(a_acc_out),   32'd4);
    chk("clr_frame_ovf",   32'(a_ovf),       32'd0);

    // clr in HOLD without out_ready
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_hold_valid", 32'(a_out_valid), 32'd0);
    chk("clr_hold_acc",   32'(a_acc_out),   32'd0);

    // rst while holding a result
    send_a(8'd15);
    send_a(8'd30);
    send_a(8'd45);
    send_a(8'd225);
    chk("rsthold_pre_acc",   32'(a_acc_out),   32'd315);
    chk("rsthold_pre_valid", 32'(a_out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsthold_valid", 32'(a_out_valid), 32'd0);
    chk("rsthold_acc",   32'(a_acc_out),   32'd0);
    chk("rsthold_ready", 32'(a_in_ready),  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 array multiplier's 8-bit product (uo_out).
- Sums a frame of N_TERMS products into a wider accumulator using a saturating add.
- Presents the frame result on a valid/ready output port.
- Allows the multiplier to be used for dot products across clock cycles without changing the combinational core.

Parameters:
- PROD_W, 8, width of incoming product; matches the multiplier output.
- ACC_W, 12, accumulator/result width; must be >= PROD_W.
- N_TERMS, 4, products per frame; must be >= 1. Term counter width is clog2(N_TERMS), minimum 1.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  synchronous frame abort, active-high.
- prod  input  PROD_W  product from multiplier, unsigned.
- in_valid  input  1  prod is valid this cycle.
- in_ready  output  1  block accepts prod this cycle.
- acc_out  output  ACC_W  frame sum, unsigned.
- ovf  output  1  frame saturated; qualified by out_valid.
- out_valid  output  1  acc_out/ovf hold a completed frame.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Clocking and reset: one clock domain, clk. rst is synchronous, active-high, and has highest priority.
- Reset values:
  - state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - acc_out=0.
- acc_out and ovf are driven directly from registers; no combinational path from prod.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM, accept (in_valid & in_ready):
  - sum = acc + zero-extended prod, computed at ACC_W+1 bits.
  - If sum > 2^ACC_W-1, then acc <= 2^ACC_W-1 and ovf <= 1. Otherwise acc <= sum.
  - ovf is sticky for the rest of the frame.
- Frame completion:
  - If cnt == N_TERMS-1 on accept: cnt <= 0 and state <= HOLD.
  - out_valid rises the cycle after the last accept.
  - Otherwise cnt <= cnt+1.
- in_valid low in ACCUM: no state change. Gaps between terms are allowed.
- HOLD:
  - acc_out and ovf are stable. in_valid is ignored; no input is consumed.
  - On out_valid & out_ready: acc <= 0, ovf <= 0, state <= ACCUM.
  - in_ready returns the following cycle. There is no same-cycle bypass.
- Throughput: minimum N_TERMS+1 cycles per frame.
- Latency: 1 cycle from the last accept to out_valid.
- clr:
  - Any state: next cycle acc=0, cnt=0, ovf=0, state=ACCUM, out_valid=0.
  - If clr coincides with an input accept, the input is dropped.
  - If clr coincides with an output handshake, the handshake is treated as completed. The result is lost to the block; downstream saw it.
  - clr is evaluated before accept/handshake logic.
- N_TERMS=1: every accepted product forms its own frame. Alternates ACCUM and HOLD.
- rst mid-frame or in HOLD: partial sum discarded; outputs go to reset values the next cycle.
- Default sizing: 4 terms × max product 225 = 900, which fits in 12 bits. ovf can then only assert under parameter overrides.

Test Plan:
- Reset: hold rst 2 cycles, then release. Required: out_valid=0, in_ready=1, acc_out=0, ovf=0.
- Basic frame (defaults): prod 15, 30, 45, 225 on consecutive cycles. Required: out_valid=1 one cycle after the 4th accept, acc_out=315, ovf=0, in_ready=0 in HOLD.
- Backpressure and gaps: send the same products with idle cycles between them, and hold out_ready=0 for 5 cycles while in_valid=1 and prod=99.
  - Required: acc_out stays 315, no input consumed.
  - After the out_ready pulse, the next frame of four 1's yields acc_out=4.
- Saturation (ACC_W=10, N_TERMS=8): eight products of 225.
  - Required: acc saturates at the 5th accept (1125 > 1023).
  - Final acc_out=1023, ovf=1; the next frame starts with ovf=0.
- clr mid-frame: accept 10, 20, then assert clr with in_valid=1 and prod=50 in the same cycle, then send four products of 1.
  - Required: the 50 is dropped, acc_out=4, ovf=0.
- rst in HOLD (acc_out=315, out_valid=1): pulse rst. Required: next cycle out_valid=0, acc_out=0, in_ready=1.
